// File: rtl/adex_loader_pkg.sv
// rtl/adex_loader_pkg.sv - shared constants, TX state encoding and slot nibble helper for the AdEx parameter loader
package adex_loader_pkg;

  localparam logic [3:0] HEADER_NIB = 4'h0;
  localparam logic [3:0] FOOTER_NIB = 4'hF;
  localparam int         NUM_PARAMS = 7;
  localparam int         NUM_SLOTS  = 16;
  localparam logic [3:0] LAST_SLOT  = 4'(NUM_SLOTS - 1);

  // Byte positions inside the parameter frame, most significant byte sent first
  localparam int IDX_DELTAT = 0;
  localparam int IDX_TAUW   = 1;
  localparam int IDX_A      = 2;
  localparam int IDX_B      = 3;
  localparam int IDX_VRESET = 4;
  localparam int IDX_VT     = 5;
  localparam int IDX_IBIAS  = 6;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_SLOT_LO = 3'd1,
    TX_SLOT_HI = 3'd2,
    TX_HOLD    = 3'd3,
    TX_DONE    = 3'd4
  } tx_state_t;

  // Nibble carried by a given slot: header, 14 data nibbles high-first, footer
  function automatic logic [3:0] slot_nibble(input logic [55:0] params, input logic [3:0] slot);
    logic [55:0] shifted;
    logic [3:0]  nib;
    shifted = params << {slot - 4'd1, 2'b00};
    if (slot == 4'd0)
      nib = HEADER_NIB;
    else if (slot == LAST_SLOT)
      nib = FOOTER_NIB;
    else
      nib = shifted[55:52];
    return nib;
  endfunction

endpackage

// File: rtl/adex_strobe_timer.sv
// rtl/adex_strobe_timer.sv - loadable 8-bit down-counter with a one-cycle expiry pulse
module adex_strobe_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt;

  // Load a phase length, then count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 8'd0;
    else if (load)
      cnt <= load_val;
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  // Expiry flags the last cycle of the loaded phase so the owner can reload on the same edge
  assign expire = (cnt == 8'd1);

endmodule

// File: rtl/adex_param_loader_tx.sv
// rtl/adex_param_loader_tx.sv - nibble-serial AdEx parameter frame transmitter (optional abort: ADEX_LOADER_TX_ABORT_EN)
module adex_param_loader_tx
  import adex_loader_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [55:0] param_bus,
`ifdef ADEX_LOADER_TX_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic        load_mode_o,
  output logic        load_enable_o,
  output logic [3:0]  nibble_o
);

  localparam logic [7:0] HALF_LEN = 8'(HALF_PERIOD);
  localparam logic [7:0] HOLD_LEN = 8'(HOLD_CYCLES);

  tx_state_t   state, state_nxt;
  logic [3:0]  slot;
  logic [55:0] snapshot;
  logic        timer_load;
  logic [7:0]  timer_val;
  logic        timer_expire;
  logic        abort_req;

`ifdef ADEX_LOADER_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  adex_strobe_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= TX_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and timer reload; every phase entry reloads the timer on the same edge
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_val  = HALF_LEN;
    case (state)
      TX_IDLE: begin
        if (start) begin
          state_nxt  = TX_SLOT_LO;
          timer_load = 1'b1;
        end
      end
      TX_SLOT_LO: begin
        if (timer_expire) begin
          state_nxt  = TX_SLOT_HI;
          timer_load = 1'b1;
        end
      end
      TX_SLOT_HI: begin
        if (timer_expire) begin
          timer_load = 1'b1;
          if (slot == LAST_SLOT) begin
            state_nxt = TX_HOLD;
            timer_val = HOLD_LEN;
          end else begin
            state_nxt = TX_SLOT_LO;
          end
        end
      end
      TX_HOLD: begin
        if (timer_expire)
          state_nxt = TX_DONE;
      end
      TX_DONE:  state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
    // Start wins in IDLE; abort only acts once a frame is running
    if (abort_req && (state != TX_IDLE))
      state_nxt = TX_IDLE;
  end

  // Frame snapshot and slot counter, restarted on every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= 56'd0;
      slot     <= 4'd0;
    end else if ((state == TX_IDLE) && (state_nxt == TX_SLOT_LO)) begin
      snapshot <= param_bus;
      slot     <= 4'd0;
    end else if ((state == TX_SLOT_HI) && (state_nxt == TX_SLOT_LO)) begin
      slot     <= slot + 4'd1;
    end
  end

  // Nibble changes only on entry to a low phase and clears when the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nibble_o <= 4'd0;
    else if ((state == TX_IDLE) && (state_nxt == TX_SLOT_LO))
      nibble_o <= HEADER_NIB;
    else if ((state == TX_SLOT_HI) && (state_nxt == TX_SLOT_LO))
      nibble_o <= slot_nibble(snapshot, slot + 4'd1);
    else if (state_nxt == TX_IDLE)
      nibble_o <= 4'd0;
  end

  // Pin-level outputs decoded straight from the state register so reset clears them at once
  always_comb begin
    busy          = (state == TX_SLOT_LO) || (state == TX_SLOT_HI) || (state == TX_HOLD);
    load_mode_o   = busy;
    load_enable_o = (state == TX_SLOT_HI);
    done          = (state == TX_DONE);
  end

endmodule

// File: tb/tb_adex_param_loader_tx.sv
// tb/tb_adex_param_loader_tx.sv - randomized self-checking bench for adex_param_loader_tx
module tb_adex_param_loader_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, b_start;
  logic [55:0] a_param, b_param;
  logic        a_busy, a_done, a_lm, a_le;
  logic [3:0]  a_nib;
  logic        b_busy, b_done, b_lm, b_le;
  logic [3:0]  b_nib;
`ifdef ADEX_LOADER_TX_ABORT_EN
  logic        a_abort, b_abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;
  logic       s_busy, s_done, s_lm, s_le;
  logic [3:0] s_nib;

  always #5 clk = ~clk;

  adex_param_loader_tx #(.HALF_PERIOD(4), .HOLD_CYCLES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .param_bus(a_param),
`ifdef ADEX_LOADER_TX_ABORT_EN
    .abort(a_abort),
`endif
    .busy(a_busy), .done(a_done), .load_mode_o(a_lm), .load_enable_o(a_le), .nibble_o(a_nib)
  );

  adex_param_loader_tx #(.HALF_PERIOD(2), .HOLD_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .param_bus(b_param),
`ifdef ADEX_LOADER_TX_ABORT_EN
    .abort(b_abort),
`endif
    .busy(b_busy), .done(b_done), .load_mode_o(b_lm), .load_enable_o(b_le), .nibble_o(b_nib)
  );

  always_comb begin
    s_busy = (sel != 0) ? b_busy : a_busy;
    s_done = (sel != 0) ? b_done : a_done;
    s_lm   = (sel != 0) ? b_lm   : a_lm;
    s_le   = (sel != 0) ? b_le   : a_le;
    s_nib  = (sel != 0) ? b_nib  : a_nib;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: header 0, the seven bytes as high/low nibbles, footer F, packed first-sent in the MSBs
  function automatic logic [63:0] ref_seq(input logic [55:0] p);
    logic [63:0] s;
    logic [7:0]  byte_v;
    s = 64'h0;
    for (int i = 0; i < 7; i++) begin
      byte_v = 8'((p >> (8 * (6 - i))) & 56'hFF);
      s = (s << 8) | {56'h0, byte_v};
    end
    s = (s << 4) | 64'hF;
    return s;
  endfunction

  function automatic logic [55:0] rand_params();
    return {$urandom(), $urandom()} & 56'hFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic run_frame(input int which, input logic [55:0] p, input int hp, input int hold,
                           input string tag, output logic [63:0] seq);
    int done_k, rises, viol, lm_cnt, low_run, high_run;
    logic prev_le;
    logic [3:0] prev_nib;
    sel = which;
    done_k = 0; rises = 0; viol = 0; lm_cnt = 0; low_run = 0; high_run = 0;
    prev_le = 1'b0; prev_nib = 4'd0; seq = 64'h0;
    @(negedge clk);
    if (which != 0) begin b_param = p; b_start = 1'b1; end
    else begin a_param = p; a_start = 1'b1; end
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (k == 1) begin a_start = 1'b0; b_start = 1'b0; end
      if (s_lm) lm_cnt++;
      if (s_done && (s_busy || s_lm)) viol++;
      if ((s_nib != prev_nib) && !(prev_le && !s_le)) viol++;
      if (s_le && !prev_le) begin
        rises++;
        seq = {seq[59:0], s_nib};
        if (low_run != hp) viol++;
        low_run = 0;
        high_run = 0;
      end
      if (!s_le && prev_le && (high_run != hp)) viol++;
      if (s_le) high_run++;
      else if (s_busy) low_run++;
      prev_le = s_le;
      prev_nib = s_nib;
      if (s_done) begin
        done_k = k;
        break;
      end
    end
    check({tag, ".rises"}, 64'(rises), 64'd16);
    check({tag, ".nibbles"}, seq, ref_seq(p));
    check({tag, ".done_cycle"}, 64'(done_k), 64'(1 + 32 * hp + hold));
    check({tag, ".lm_cycles"}, 64'(lm_cnt), 64'(32 * hp + hold));
    check({tag, ".timing_viol"}, 64'(viol), 64'd0);
    @(negedge clk);
    check({tag, ".idle_after"}, {56'h0, s_busy, s_done, s_lm, s_le, s_nib}, 64'h0);
  endtask

  initial begin
    logic [63:0] seq;
    logic [55:0] p;
    int dones, first_done_k, rise_after_k, viol, seen_done;
    logic prev_busy;

    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; a_param = '0; b_param = '0;
`ifdef ADEX_LOADER_TX_ABORT_EN
    a_abort = 1'b0; b_abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_a", {56'h0, a_busy, a_done, a_lm, a_le, a_nib}, 64'h0);
    check("reset_b", {56'h0, b_busy, b_done, b_lm, b_le, b_nib}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known vector
    run_frame(0, 56'h82_64_02_28_BF_CE_90, 4, 4, "vec_a", seq);
    check("vec_a.literal", seq, 64'h0826_4022_8BFC_E90F);

    // Random frames on both timings
    for (int i = 0; i < 5; i++) run_frame(0, rand_params(), 4, 4, $sformatf("rnd_a%0d", i), seq);
    run_frame(1, 56'h82_64_02_28_BF_CE_90, 2, 1, "vec_b", seq);
    for (int i = 0; i < 3; i++) run_frame(1, rand_params(), 2, 1, $sformatf("rnd_b%0d", i), seq);

    // Start held for 300 cycles: two completed frames, back-to-back
    sel = 0; dones = 0; first_done_k = 0; rise_after_k = 0; viol = 0; prev_busy = 1'b0;
    @(negedge clk);
    a_param = rand_params(); a_start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (a_done) begin
        dones++;
        if (first_done_k == 0) first_done_k = k;
      end
      if (a_done && a_busy) viol++;
      if (a_busy && !prev_busy && (first_done_k != 0) && (rise_after_k == 0)) rise_after_k = k;
      prev_busy = a_busy;
    end
    a_start = 1'b0;
    check("held.dones", 64'(dones), 64'd2);
    check("held.first_done", 64'(first_done_k), 64'd133);
    check("held.restart_gap", 64'(rise_after_k - first_done_k), 64'd2);
    check("held.busy_in_done", 64'(viol), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 400 && seen_done == 0; k++) begin
      @(negedge clk);
      if (a_done) seen_done = 1;
    end
    check("held.drain", 64'(seen_done), 64'd1);
    repeat (2) @(negedge clk);

    // Reset in slot 9 high phase
    p = rand_params();
    seq = ref_seq(p);
    @(negedge clk);
    a_param = p; a_start = 1'b1;
    for (int k = 1; k <= 77; k++) begin
      @(negedge clk);
      if (k == 1) a_start = 1'b0;
    end
    check("rst.slot9_hi", {59'h0, a_le, a_nib}, {59'h0, 1'b1, seq[27:24]});
    rst_n = 1'b0;
    #1;
    check("rst.async_clear", {56'h0, a_busy, a_done, a_lm, a_le, a_nib}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_done || a_busy || a_lm) seen_done++;
    end
    check("rst.stays_idle", 64'(seen_done), 64'd0);

`ifdef ADEX_LOADER_TX_ABORT_EN
    // Abort during slot 5 low phase
    @(negedge clk);
    a_param = rand_params(); a_start = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 1) a_start = 1'b0;
    end
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort.outputs", {60'h0, a_busy, a_done, a_lm, a_le}, 64'h0);
    seen_done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_done || a_busy) seen_done++;
    end
    check("abort.no_done", 64'(seen_done), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
